// File: rtl/seven_segment_scan_driver_if.sv
// Bus between a value source and the 7-segment scan driver.
// The source drives the display data and the live controls.
// The driver returns the pin-level segment and anode drive plus a frame marker.
interface seven_segment_scan_driver_if #(
  parameter int Digits = 4
);
  logic [Digits*4-1:0] value;
  logic [Digits-1:0]   dp;
  logic                load;
  logic                hex_mode;
  logic                blank_lz;
  logic [3:0]          brightness;
  logic [7:0]          segments;
  logic [Digits-1:0]   anodes;
  logic                frame_done;

  modport master (
    output value, dp, load, hex_mode, blank_lz, brightness,
    input  segments, anodes, frame_done
  );

  modport slave (
    input  value, dp, load, hex_mode, blank_lz, brightness,
    output segments, anodes, frame_done
  );
endinterface

// File: rtl/seven_segment_scan_driver.sv
// Time-multiplexed 7-segment display driver.
// The driver captures value/dp into a shadow register on load.
// It scans one digit per ClkDivide clocks, with decimal or hex decode,
// leading-zero blanking and 16-level PWM brightness.
// All pin outputs are registered, and they follow the scan state with one cycle of latency.
module seven_segment_scan_driver #(
  parameter int Digits    = 4,
  parameter int ClkDivide = 1000,
  parameter bit ActiveLow = 1'b1
) (
  input logic                        clk,
  input logic                        rst,
  seven_segment_scan_driver_if.slave bus
);
  localparam int Width  = Digits * 4;
  localparam int TickW  = (ClkDivide > 1) ? $clog2(ClkDivide) : 1;
  localparam int DigitW = (Digits > 1) ? $clog2(Digits) : 1;
  // tick*16 and (brightness+1)*ClkDivide both fit below 2^(TickW+5).
  localparam int PwmW   = TickW + 6;

  localparam logic [TickW-1:0]  LastTick  = TickW'(ClkDivide - 1);
  localparam logic [DigitW-1:0] LastDigit = DigitW'(Digits - 1);
  localparam logic [PwmW-1:0]   DivideW   = PwmW'(ClkDivide);
  localparam logic [7:0]        SegPol    = {8{ActiveLow}};
  localparam logic [Digits-1:0] AnPol     = {Digits{ActiveLow}};

  logic [TickW-1:0]  tick_r;
  logic [DigitW-1:0] digit_r;
  logic [Width-1:0]  shadow_value_r;
  logic [Digits-1:0] shadow_dp_r;
  logic [7:0]        segments_r;
  logic [Digits-1:0] anodes_r;
  logic              frame_done_r;

  logic [3:0]        nibble_s;
  logic              dp_bit_s;
  logic              lz_run_s;
  logic              lz_s;
  logic              blank_s;
  logic [Digits-1:0] onehot_s;
  logic [6:0]        glyph_s;
  logic [PwmW-1:0]   tick_scaled_s;
  logic [PwmW-1:0]   limit_s;
  logic              pwm_on_s;

  // Logical g..a pattern for one code. Codes 10-15 are dark unless hex is set.
  function automatic logic [6:0] decode_digit(input logic [3:0] code, input logic hex);
    logic [6:0] seg;
    case (code)
      4'h0:    seg = 7'h3F;
      4'h1:    seg = 7'h06;
      4'h2:    seg = 7'h5B;
      4'h3:    seg = 7'h4F;
      4'h4:    seg = 7'h66;
      4'h5:    seg = 7'h6D;
      4'h6:    seg = 7'h7D;
      4'h7:    seg = 7'h07;
      4'h8:    seg = 7'h7F;
      4'h9:    seg = 7'h6F;
      4'hA:    seg = hex ? 7'h77 : 7'h00;
      4'hB:    seg = hex ? 7'h7C : 7'h00;
      4'hC:    seg = hex ? 7'h39 : 7'h00;
      4'hD:    seg = hex ? 7'h5E : 7'h00;
      4'hE:    seg = hex ? 7'h79 : 7'h00;
      4'hF:    seg = hex ? 7'h71 : 7'h00;
      default: seg = 7'h00;
    endcase
    return seg;
  endfunction

  // Pick the selected digit's nibble and dp, and find whether it sits in the leading-zero run.
  always_comb begin
    nibble_s = 4'h0;
    dp_bit_s = 1'b0;
    lz_run_s = 1'b1;
    lz_s     = 1'b0;
    onehot_s = {Digits{1'b0}};
    for (int i = Digits - 1; i >= 0; i--) begin
      lz_run_s = lz_run_s & (shadow_value_r[i*4 +: 4] == 4'h0);
      if (DigitW'(i) == digit_r) begin
        nibble_s    = shadow_value_r[i*4 +: 4];
        dp_bit_s    = shadow_dp_r[i];
        lz_s        = lz_run_s;
        onehot_s[i] = 1'b1;
      end else begin
        onehot_s[i] = 1'b0;
      end
    end
  end

  // Glyph with blanking, plus the PWM on-window for the current tick.
  always_comb begin
    blank_s       = bus.blank_lz & lz_s & (digit_r != {DigitW{1'b0}});
    glyph_s       = blank_s ? 7'h00 : decode_digit(nibble_s, bus.hex_mode);
    tick_scaled_s = PwmW'({tick_r, 4'b0000});
    limit_s       = (PwmW'(bus.brightness) + PwmW'(1)) * DivideW;
    pwm_on_s      = (bus.brightness == 4'hF) | (tick_scaled_s < limit_s);
  end

  // Scan counters, shadow capture and registered pin drive.
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_r         <= {TickW{1'b0}};
      digit_r        <= {DigitW{1'b0}};
      shadow_value_r <= {Width{1'b0}};
      shadow_dp_r    <= {Digits{1'b0}};
      segments_r     <= SegPol;
      anodes_r       <= AnPol;
      frame_done_r   <= 1'b0;
    end else begin
      if (tick_r == LastTick) begin
        tick_r  <= {TickW{1'b0}};
        digit_r <= (digit_r == LastDigit) ? {DigitW{1'b0}} : digit_r + DigitW'(1);
      end else begin
        tick_r  <= tick_r + TickW'(1);
      end

      if (bus.load) begin
        shadow_value_r <= bus.value;
        shadow_dp_r    <= bus.dp;
      end

      if (pwm_on_s) begin
        segments_r <= {dp_bit_s, glyph_s} ^ SegPol;
        anodes_r   <= onehot_s ^ AnPol;
      end else begin
        segments_r <= SegPol;
        anodes_r   <= AnPol;
      end

      frame_done_r <= (tick_r == LastTick) & (digit_r == LastDigit);
    end
  end

  assign bus.segments   = segments_r;
  assign bus.anodes     = anodes_r;
  assign bus.frame_done = frame_done_r;
endmodule

// File: tb/tb_seven_segment_scan_driver.sv
// Scoreboard bench for seven_segment_scan_driver (Digits=4, ClkDivide=16, ActiveLow=1).
// Stimulus queues expected pin values stamped with the clock cycle they must appear on.
// A monitor pops each entry on that cycle's falling edge and compares it.
module tb_seven_segment_scan_driver;
  localparam int Digits    = 4;
  localparam int ClkDivide = 16;

  typedef struct {
    int         cyc;
    logic [7:0] seg;
    logic [3:0] an;
    logic       fd;
    string      name;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   base = 0;
  int   total = 0;
  int   bad = 0;
  exp_t sb_q[$];
  logic [7:0] tbl_1234 [4] = '{8'h66, 8'h4F, 8'h5B, 8'h06};

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  seven_segment_scan_driver_if #(.Digits(Digits)) bus ();

  seven_segment_scan_driver #(
    .Digits(Digits), .ClkDivide(ClkDivide), .ActiveLow(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  // Expected values are given in logical polarity; the pins are active low.
  task automatic expect_at(input int c, input logic [7:0] seg_l, input logic [3:0] an_l,
                           input logic fd, input string name);
    exp_t e;
    e.cyc = c; e.seg = ~seg_l; e.an = ~an_l; e.fd = fd; e.name = name;
    sb_q.push_back(e);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    int c0;
    c0 = cyc;
    rst = 1'b1;
    for (int i = 1; i <= n; i++) expect_at(c0 + i, 8'h00, 4'h0, 1'b0, "reset_off");
    repeat (n) @(negedge clk);
    rst = 1'b0;
    base = cyc;
  endtask

  task automatic load_value(input logic [15:0] v, input logic [3:0] d);
    bus.value = v;
    bus.dp    = d;
    bus.load  = 1'b1;
    @(negedge clk);
    bus.load  = 1'b0;
  endtask

  // Monitor: compare every entry that is due on this cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
        e = sb_q.pop_front();
        total++;
        if (e.cyc != cyc) begin
          bad++;
          $display("FAIL %s: check for cycle %0d missed, now at cycle %0d", e.name, e.cyc, cyc);
        end else if (bus.segments !== e.seg || bus.anodes !== e.an || bus.frame_done !== e.fd) begin
          bad++;
          $display("FAIL %s @%0d: got seg=%h an=%h fd=%b, need seg=%h an=%h fd=%b",
                   e.name, cyc - base, bus.segments, bus.anodes, bus.frame_done, e.seg, e.an, e.fd);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, cycle=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    int d;
    bit on;
    bus.value = 16'h1234; bus.dp = 4'h0; bus.load = 1'b0;
    bus.hex_mode = 1'b0; bus.blank_lz = 1'b0; bus.brightness = 4'hF;
    @(negedge clk);

    // Reset state, then basic scan of 1234 at full brightness.
    do_reset(3);
    expect_at(base + 1,   8'h3F, 4'b0001, 1'b0, "load_edge_old_shadow");
    expect_at(base + 2,   8'h66, 4'b0001, 1'b0, "digit0");
    expect_at(base + 16,  8'h66, 4'b0001, 1'b0, "digit0_end");
    expect_at(base + 17,  8'h4F, 4'b0010, 1'b0, "digit1");
    expect_at(base + 33,  8'h5B, 4'b0100, 1'b0, "digit2");
    expect_at(base + 49,  8'h06, 4'b1000, 1'b0, "digit3");
    expect_at(base + 63,  8'h06, 4'b1000, 1'b0, "pre_frame");
    expect_at(base + 64,  8'h06, 4'b1000, 1'b1, "frame_done");
    expect_at(base + 65,  8'h66, 4'b0001, 1'b0, "wrap_digit0");
    expect_at(base + 128, 8'h06, 4'b1000, 1'b1, "frame_done2");
    load_value(16'h1234, 4'h0);
    wait_until(base + 130);

    // Leading-zero blanking with 00A0, decimal then hex.
    do_reset(1);
    bus.blank_lz = 1'b1; bus.hex_mode = 1'b0;
    expect_at(base + 1,  8'h3F, 4'b0001, 1'b0, "zero_value_digit0");
    expect_at(base + 2,  8'h3F, 4'b0001, 1'b0, "lz_digit0");
    expect_at(base + 17, 8'h00, 4'b0010, 1'b0, "code_a_dec_blank");
    expect_at(base + 33, 8'h00, 4'b0100, 1'b0, "lz_digit2");
    expect_at(base + 49, 8'h00, 4'b1000, 1'b0, "lz_digit3");
    expect_at(base + 65, 8'h3F, 4'b0001, 1'b0, "lz_digit0_again");
    expect_at(base + 81, 8'h77, 4'b0010, 1'b0, "code_a_hex");
    expect_at(base + 97, 8'h00, 4'b0100, 1'b0, "lz_digit2_hex");
    load_value(16'h00A0, 4'h0);
    wait_until(base + 60);
    bus.hex_mode = 1'b1;
    wait_until(base + 100);

    // PWM: brightness 3 gives the first 4 ticks of each slot, brightness 0 only the first.
    do_reset(1);
    bus.blank_lz = 1'b0; bus.hex_mode = 1'b0; bus.brightness = 4'd3;
    load_value(16'h1234, 4'h0);
    for (int k = 17; k <= 80; k++) begin
      t = (k - 1) % 16; d = ((k - 1) / 16) % 4; on = (t < 4);
      expect_at(base + k, on ? tbl_1234[d] : 8'h00, on ? 4'(4'b0001 << d) : 4'h0,
                (k == 64), "pwm_b3");
    end
    wait_until(base + 80);
    bus.brightness = 4'd0;
    for (int k = 81; k <= 144; k++) begin
      t = (k - 1) % 16; d = ((k - 1) / 16) % 4; on = (t < 1);
      expect_at(base + k, on ? tbl_1234[d] : 8'h00, on ? 4'(4'b0001 << d) : 4'h0,
                (k == 128), "pwm_b0");
    end
    wait_until(base + 146);

    // Shadow register behaviour, decimal points, blanked digit keeping its dp.
    do_reset(1);
    bus.brightness = 4'hF;
    load_value(16'h1234, 4'h0);
    expect_at(base + 17,  8'h4F, 4'b0010, 1'b0, "no_load_hold");
    expect_at(base + 21,  8'h4F, 4'b0010, 1'b0, "load_edge_old");
    expect_at(base + 22,  8'h07, 4'b0010, 1'b0, "load_next_edge");
    expect_at(base + 33,  8'hFD, 4'b0100, 1'b0, "dp2_lit");
    expect_at(base + 49,  8'h6D, 4'b1000, 1'b0, "dp3_dark");
    expect_at(base + 65,  8'h7F, 4'b0001, 1'b0, "dp0_dark");
    expect_at(base + 81,  8'h00, 4'b0010, 1'b0, "blank_lz_d1");
    expect_at(base + 97,  8'h80, 4'b0100, 1'b0, "blank_dp_kept");
    expect_at(base + 113, 8'h00, 4'b1000, 1'b0, "blank_lz_d3");
    expect_at(base + 129, 8'h3F, 4'b0001, 1'b0, "zero_shows_0");
    wait_until(base + 5);
    bus.value = 16'h5678;
    wait_until(base + 20);
    load_value(16'h5678, 4'b0100);
    wait_until(base + 70);
    bus.blank_lz = 1'b1;
    load_value(16'h0000, 4'b0100);
    wait_until(base + 130);

    // Reset during digit 2 restarts the scan with a cleared shadow.
    do_reset(1);
    bus.blank_lz = 1'b0; bus.hex_mode = 1'b0; bus.brightness = 4'hF;
    load_value(16'h1234, 4'h0);
    expect_at(base + 33, 8'h5B, 4'b0100, 1'b0, "pre_reset_digit2");
    wait_until(base + 40);
    do_reset(1);
    expect_at(base + 1,  8'h3F, 4'b0001, 1'b0, "restart_digit0");
    expect_at(base + 2,  8'h3F, 4'b0001, 1'b0, "restart_shadow0");
    expect_at(base + 17, 8'h3F, 4'b0010, 1'b0, "restart_digit1");
    wait_until(base + 20);

    for (int i = 0; i < 200 && sb_q.size() > 0; i++) @(negedge clk);
    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d entries left, need 0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
